w5300_sock_opener: RTL



---
 rtl/w5300_sock_opener_pkg.sv | 51 +++++
 rtl/w5300_sock_opener_reg_access.sv | 64 ++++++
 rtl/w5300_sock_opener.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/w5300_sock_opener_pkg.sv
// Shared W5300 register map, enums and helpers for the UDP socket opener.
// W5300_SOCK_IMR_EN adds the WR_IMR state to the sequencer enum.
package w5300_sock_opener_pkg;

    typedef enum logic {ADDR_OP_WR = 1'b0, ADDR_OP_RD = 1'b1} addr_operation_e;

    typedef enum logic [2:0] {
        SOCKET_0, SOCKET_1, SOCKET_2, SOCKET_3,
        SOCKET_4, SOCKET_5, SOCKET_6, SOCKET_7
    } socket_e;

    // Socket 0 register offsets; socket n sits 0x40*n above these.
    localparam logic [9:0] SN_MR     = 10'h200;
    localparam logic [9:0] SN_CR     = 10'h202;
    localparam logic [9:0] SN_IMR    = 10'h204;
    localparam logic [9:0] SN_SSR    = 10'h208;
    localparam logic [9:0] SN_PORTR  = 10'h20A;
    localparam logic [9:0] SN_DPORTR = 10'h212;
    localparam logic [9:0] SN_DIPR0  = 10'h214;
    localparam logic [9:0] SN_DIPR2  = 10'h216;

    localparam logic [15:0] MR_UDP   = 16'h0002;
    localparam logic [15:0] CR_OPEN  = 16'h0001;
    localparam logic [15:0] CR_CLOSE = 16'h0010;
    localparam logic [15:0] IMR_MASK = 16'h001C;

    localparam logic [7:0] SN_SSR_SOCK_UDP = 8'h22;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MR,
        ST_WR_PORT,
        ST_WR_DIP0,
        ST_WR_DIP2,
        ST_WR_DPORT,
        ST_WR_OPEN,
        ST_RD_SSR,
`ifdef W5300_SOCK_IMR_EN
        ST_WR_IMR,
`endif
        ST_WR_CLOSE,
        ST_DONE
    } opener_state_e;

    typedef enum logic {ACC_IDLE, ACC_REQ} acc_state_e;

    function automatic logic [9:0] sock_reg_addr(input logic [9:0] offset, input logic [2:0] n);
        return offset + ({7'd0, n} << 6);
    endfunction

endpackage

// File: rtl/w5300_sock_opener_reg_access.sv
// Register-port master: holds op/addr/wdata for the whole req..ack window and
// turns a go pulse into one request, reporting completion with a done pulse.
module w5300_reg_access_fsm
    import w5300_sock_opener_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  addr_operation_e op,
    input  logic [9:0]      addr,
    input  logic [15:0]     wdata,
    output logic            done,
    output acc_state_e      acc_state,
    output logic            reg_req,
    output logic            reg_op,
    output logic [9:0]      reg_addr,
    output logic [15:0]     reg_wdata,
    input  logic            reg_ack
);

    acc_state_e next_state;
    logic       op_q;
    logic [9:0] addr_q;
    logic [15:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_state <= ACC_IDLE;
            op_q      <= 1'b0;
            addr_q    <= 10'd0;
            wdata_q   <= 16'd0;
        end else begin
            acc_state <= next_state;
            if (acc_state == ACC_IDLE && go) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // A request is only raised a clock after go, so the idle cycle following
    // each ack is the mandatory low gap on reg_req.
    always_comb begin
        next_state = acc_state;
        done       = 1'b0;
        case (acc_state)
            ACC_IDLE: if (go) next_state = ACC_REQ;
            ACC_REQ: begin
                if (reg_ack) begin
                    done       = 1'b1;
                    next_state = ACC_IDLE;
                end
            end
            default: next_state = ACC_IDLE;
        endcase
    end

    assign reg_req   = (acc_state == ACC_REQ);
    assign reg_op    = op_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: rtl/w5300_sock_opener.sv
// UDP socket bring-up sequencer for the W5300: programs and opens sockets
// 0..NUM_SOCKETS-1 in turn. W5300_SOCK_IMR_EN adds a Sn_IMR write after each open.
module w5300_sock_opener
    import w5300_sock_opener_pkg::*;
#(
    parameter int          NUM_SOCKETS   = 2,
    parameter logic [15:0] SRC_PORT_BASE = 16'd5000,
    parameter int          POLL_LIMIT    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            dst_ip,
    input  logic [15:0]            dst_port,
    output logic                   reg_req,
    output logic                   reg_op,
    output logic [9:0]             reg_addr,
    output logic [15:0]            reg_wdata,
    input  logic                   reg_ack,
    input  logic [15:0]            reg_rdata,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_SOCKETS-1:0] sock_open,
    output logic [NUM_SOCKETS-1:0] sock_err,
    output opener_state_e          fsm_state
);

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam socket_e SOCK_LAST = socket_e'(3'(NUM_SOCKETS - 1));

    opener_state_e    state, next_state, adv_state;
    socket_e          sock_idx;
    logic [PW-1:0]    poll_cnt;
    logic [31:0]      ip_q;
    logic [15:0]      port_q;
    logic             go, acc_done, start_ok, hit, poll_out;
    addr_operation_e  op;
    logic [9:0]       offset;
    logic [15:0]      wdata;
    acc_state_e       acc_state;
    logic [NUM_SOCKETS-1:0] sock_bit;

    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
    assign hit       = (reg_rdata & 16'h00FF) == {8'h00, SN_SSR_SOCK_UDP};
    assign poll_out  = (poll_cnt == POLL_LAST);
    assign sock_bit  = NUM_SOCKETS'(1) << sock_idx;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign go        = busy && (acc_state == ACC_IDLE);
    assign fsm_state = state;
    // Moving on to the next socket is decided in the cycle of the final ack,
    // so back-to-back sockets keep the two-cycle access rhythm.
    assign adv_state = (sock_idx == SOCK_LAST) ? ST_DONE : ST_WR_MR;

    always_comb begin
        next_state = state;
        op         = ADDR_OP_WR;
        offset     = SN_MR;
        wdata      = 16'h0000;
        case (state)
            ST_IDLE, ST_DONE: if (start_ok) next_state = ST_WR_MR;
            ST_WR_MR: begin
                wdata = MR_UDP;
                if (acc_done) next_state = ST_WR_PORT;
            end
            ST_WR_PORT: begin
                offset = SN_PORTR;
                wdata  = SRC_PORT_BASE + {13'd0, sock_idx};
                if (acc_done) next_state = ST_WR_DIP0;
            end
            ST_WR_DIP0: begin
                offset = SN_DIPR0;
                wdata  = ip_q[31:16];
                if (acc_done) next_state = ST_WR_DIP2;
            end
            ST_WR_DIP2: begin
                offset = SN_DIPR2;
                wdata  = ip_q[15:0];
                if (acc_done) next_state = ST_WR_DPORT;
            end
            ST_WR_DPORT: begin
                offset = SN_DPORTR;
                wdata  = port_q;
                if (acc_done) next_state = ST_WR_OPEN;
            end
            ST_WR_OPEN: begin
                offset = SN_CR;
                wdata  = CR_OPEN;
                if (acc_done) next_state = ST_RD_SSR;
            end
            ST_RD_SSR: begin
                op     = ADDR_OP_RD;
                offset = SN_SSR;
                if (acc_done) begin
                    if (hit) begin
`ifdef W5300_SOCK_IMR_EN
                        next_state = ST_WR_IMR;
`else
                        next_state = adv_state;
`endif
                    end else if (poll_out) begin
                        next_state = ST_WR_CLOSE;
                    end
                end
            end
`ifdef W5300_SOCK_IMR_EN
            ST_WR_IMR: begin
                offset = SN_IMR;
                wdata  = IMR_MASK;
                if (acc_done) next_state = adv_state;
            end
`endif
            ST_WR_CLOSE: begin
                offset = SN_CR;
                wdata  = CR_CLOSE;
                if (acc_done) next_state = adv_state;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sock_idx  <= SOCKET_0;
            poll_cnt  <= '0;
            ip_q      <= 32'd0;
            port_q    <= 16'd0;
            sock_open <= '0;
            sock_err  <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (next_state == ST_DONE) && (state != ST_DONE);
            if (start_ok) begin
                ip_q      <= dst_ip;
                port_q    <= dst_port;
                sock_open <= '0;
                sock_err  <= '0;
                sock_idx  <= SOCKET_0;
                poll_cnt  <= '0;
            end else if (acc_done) begin
                if (state == ST_RD_SSR) begin
                    if (hit) sock_open <= sock_open | sock_bit;
                    else if (poll_out) sock_err <= sock_err | sock_bit;
                    else poll_cnt <= poll_cnt + 1'b1;
                end
                if (next_state == ST_WR_MR) begin
                    sock_idx <= socket_e'(sock_idx + 3'd1);
                    poll_cnt <= '0;
                end
            end
        end
    end

    w5300_reg_access_fsm u_access (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .op        (op),
        .addr      (sock_reg_addr(offset, sock_idx)),
        .wdata     (wdata),
        .done      (acc_done),
        .acc_state (acc_state),
        .reg_req   (reg_req),
        .reg_op    (reg_op),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack)
    );

endmodule
